spi_recv_axis: RTL and testbench



---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_rx_fifo.sv | 79 +++++++
 rtl/spi_recv_axis.sv | 189 ++++++++++++++++++
 tb/tb_spi_recv_axis.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions for the oversampled SPI receiver: mode encodings and
// the rule that picks which synchronised SPI clock edge carries valid MOSI data.
package spi_pkg;

    localparam logic [1:0] SPI_MODE_0 = 2'd0;
    localparam logic [1:0] SPI_MODE_1 = 2'd1;
    localparam logic [1:0] SPI_MODE_2 = 2'd2;
    localparam logic [1:0] SPI_MODE_3 = 2'd3;

    typedef enum logic {
        EDGE_RISING  = 1'b0,
        EDGE_FALLING = 1'b1
    } sample_edge_e;

    // Modes 0 and 3 capture on the rising SPI clock edge, modes 1 and 2 on the falling edge.
    function automatic sample_edge_e sample_edge(input logic cpol, input logic cpha);
        sample_edge_e pol_s;
        case ({cpol, cpha})
            SPI_MODE_0, SPI_MODE_3: pol_s = EDGE_RISING;
            SPI_MODE_1, SPI_MODE_2: pol_s = EDGE_FALLING;
            default:                pol_s = EDGE_RISING;
        endcase
        return pol_s;
    endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous first-word-fall-through FIFO: the head entry is always visible on
// dout, and a push while full is accepted only when a pop happens in the same cycle.
module spi_rx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             axis_aclk,
    input  logic             axis_aresetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] ZERO_C  = {(AW + 1){1'b0}};
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE_C = {{(AW - 1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             full_r;
    logic             empty_r;
    logic             do_push_s;
    logic             do_pop_s;
    logic [AW:0]      count_next_s;

    // Accepted push/pop decisions and the resulting occupancy.
    always_comb begin
        do_pop_s     = pop && !empty_r;
        do_push_s    = push && (!full_r || do_pop_s);
        count_next_s = count_r;
        if (do_push_s && !do_pop_s) begin
            count_next_s = count_r + ONE_C;
        end else if (do_pop_s && !do_push_s) begin
            count_next_s = count_r - ONE_C;
        end else begin
            count_next_s = count_r;
        end
    end

    // Storage array; contents need no reset because empty_r masks them.
    always_ff @(posedge axis_aclk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; flags are registered.
    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= ZERO_C;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == DEPTH_C);
            empty_r <= (count_next_s == ZERO_C);
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/spi_recv_axis.sv
// SPI-slave receiver oversampled in the axis_aclk domain; deserialises MOSI into
// DATA_WIDTH-bit words and streams them out on AXI-Stream with per-frame tlast.
module spi_recv_axis
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  axis_aclk,
    input  logic                  axis_aresetn,
    input  logic                  spi_clk,
    input  logic                  spi_mosi,
    input  logic                  spi_cs_n,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  overflow,
    output logic                  frame_err,
    input  logic                  err_clear
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT_C = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE_C  = {{(CNT_W - 1){1'b0}}, 1'b1};
    localparam sample_edge_e SAMPLE_POL_C = sample_edge(CPOL, CPHA);

    logic clk_meta_r, clk_sync_r, clk_hist_r;
    logic mosi_meta_r, mosi_sync_r;
    logic cs_meta_r, cs_sync_r, cs_hist_r;

    logic [DATA_WIDTH-1:0] shift_r;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic [DATA_WIDTH-1:0] stage_data_r;
    logic                  stage_valid_r;
    logic                  armed_r;
    logic                  overflow_r;
    logic                  frame_err_r;

    logic                  edge_hit_s;
    logic                  sample_s;
    logic                  cs_fall_s;
    logic                  cs_rise_s;
    logic                  word_done_s;
    logic [DATA_WIDTH-1:0] shift_next_s;
    logic                  fifo_push_s;
    logic [DATA_WIDTH:0]   fifo_din_s;
    logic [DATA_WIDTH:0]   fifo_dout_s;
    logic                  fifo_pop_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  overflow_set_s;
    logic                  frame_err_set_s;

    // Two-flop synchronisers; CS resets to "asserted" so a frame already in flight
    // at reset release produces no falling edge and stays ignored.
    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            clk_meta_r  <= CPOL;
            clk_sync_r  <= CPOL;
            clk_hist_r  <= CPOL;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
            cs_meta_r   <= 1'b0;
            cs_sync_r   <= 1'b0;
            cs_hist_r   <= 1'b0;
        end else begin
            clk_meta_r  <= spi_clk;
            clk_sync_r  <= clk_meta_r;
            clk_hist_r  <= clk_sync_r;
            mosi_meta_r <= spi_mosi;
            mosi_sync_r <= mosi_meta_r;
            cs_meta_r   <= spi_cs_n;
            cs_sync_r   <= cs_meta_r;
            cs_hist_r   <= cs_sync_r;
        end
    end

    // Edge detection; sampling requires CS low, so a word completion can never
    // coincide with the CS rise that ends its frame.
    always_comb begin
        case (SAMPLE_POL_C)
            EDGE_RISING:  edge_hit_s = clk_sync_r && !clk_hist_r;
            EDGE_FALLING: edge_hit_s = !clk_sync_r && clk_hist_r;
            default:      edge_hit_s = 1'b0;
        endcase
        sample_s    = edge_hit_s && !cs_sync_r && armed_r;
        cs_fall_s   = cs_hist_r && !cs_sync_r;
        cs_rise_s   = !cs_hist_r && cs_sync_r && armed_r;
        word_done_s = sample_s && (bit_cnt_r == LAST_BIT_C);
        if (MSB_FIRST) begin
            shift_next_s = {shift_r[DATA_WIDTH-2:0], mosi_sync_r};
        end else begin
            shift_next_s = {mosi_sync_r, shift_r[DATA_WIDTH-1:1]};
        end
    end

    // Staged word is released as non-last when the next word completes, or as last at CS rise.
    always_comb begin
        fifo_push_s = 1'b0;
        fifo_din_s  = {(DATA_WIDTH + 1){1'b0}};
        if (word_done_s) begin
            if (stage_valid_r) begin
                fifo_push_s = 1'b1;
                fifo_din_s  = {1'b0, stage_data_r};
            end else begin
                fifo_push_s = 1'b0;
            end
        end else if (cs_rise_s) begin
            if (stage_valid_r) begin
                fifo_push_s = 1'b1;
                fifo_din_s  = {1'b1, stage_data_r};
            end else begin
                fifo_push_s = 1'b0;
            end
        end else begin
            fifo_push_s = 1'b0;
        end
        fifo_pop_s      = !fifo_empty_s && m_axis_tready;
        overflow_set_s  = fifo_push_s && fifo_full_s && !fifo_pop_s;
        frame_err_set_s = cs_rise_s && (bit_cnt_r != {CNT_W{1'b0}});
    end

    // Shift register, bit counter, frame arming, staging and sticky error flags.
    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            shift_r       <= {DATA_WIDTH{1'b0}};
            bit_cnt_r     <= {CNT_W{1'b0}};
            stage_data_r  <= {DATA_WIDTH{1'b0}};
            stage_valid_r <= 1'b0;
            armed_r       <= 1'b0;
            overflow_r    <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            if (cs_fall_s) begin
                shift_r   <= {DATA_WIDTH{1'b0}};
                bit_cnt_r <= {CNT_W{1'b0}};
                armed_r   <= 1'b1;
            end else if (sample_s) begin
                shift_r   <= shift_next_s;
                bit_cnt_r <= word_done_s ? {CNT_W{1'b0}} : bit_cnt_r + CNT_ONE_C;
            end else if (cs_rise_s) begin
                shift_r   <= {DATA_WIDTH{1'b0}};
                bit_cnt_r <= {CNT_W{1'b0}};
                armed_r   <= 1'b0;
            end
            if (word_done_s) begin
                stage_data_r  <= shift_next_s;
                stage_valid_r <= 1'b1;
            end else if (cs_rise_s) begin
                stage_valid_r <= 1'b0;
            end
            if (overflow_set_s) begin
                overflow_r <= 1'b1;
            end else if (err_clear) begin
                overflow_r <= 1'b0;
            end
            if (frame_err_set_s) begin
                frame_err_r <= 1'b1;
            end else if (err_clear) begin
                frame_err_r <= 1'b0;
            end
        end
    end

    spi_rx_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .axis_aclk    (axis_aclk),
        .axis_aresetn (axis_aresetn),
        .push         (fifo_push_s),
        .pop          (fifo_pop_s),
        .din          (fifo_din_s),
        .dout         (fifo_dout_s),
        .full         (fifo_full_s),
        .empty        (fifo_empty_s)
    );

    assign m_axis_tvalid = !fifo_empty_s;
    assign m_axis_tdata  = fifo_empty_s ? {DATA_WIDTH{1'b0}} : fifo_dout_s[DATA_WIDTH-1:0];
    assign m_axis_tlast  = fifo_empty_s ? 1'b0 : fifo_dout_s[DATA_WIDTH];
    assign overflow      = overflow_r;
    assign frame_err     = frame_err_r;

endmodule

// File: tb/tb_spi_recv_axis.sv
// Directed bench for spi_recv_axis: seven configurations share the SPI pins, each
// with its own chip select, checked against a frame-level scoreboard.
module tb_spi_recv_axis;

    localparam int NI = 7;
    localparam int HALF = 2;
    localparam int DW_A  [NI] = '{8, 8, 8, 8, 8, 12, 8};
    localparam int DEP_A [NI] = '{16, 16, 16, 16, 16, 16, 4};
    localparam bit CPOL_A [NI] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam bit CPHA_A [NI] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam bit MSB_A  [NI] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    logic aclk, aresetn, spi_clk, spi_mosi;
    logic [NI-1:0] cs_n_v, tready_v, err_clear_v;
    logic [31:0] tdata_w [NI];
    logic tvalid_w [NI];
    logic tlast_w [NI];
    logic ovf_w [NI];
    logic ferr_w [NI];

    logic [32:0] exp_q [NI][$];
    logic [32:0] rx_log [NI][$];
    logic exp_ovf [NI];
    logic exp_ferr [NI];
    logic [31:0] tx_words [8];
    logic prev_hold [NI];
    logic [32:0] prev_beat [NI];
    int n_checks = 0;
    int n_fail = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [DW_A[g]-1:0] td_s;
        spi_recv_axis #(
            .DATA_WIDTH (DW_A[g]), .FIFO_DEPTH (DEP_A[g]),
            .CPOL (CPOL_A[g]), .CPHA (CPHA_A[g]), .MSB_FIRST (MSB_A[g])
        ) u_dut (
            .axis_aclk (aclk), .axis_aresetn (aresetn),
            .spi_clk (spi_clk), .spi_mosi (spi_mosi), .spi_cs_n (cs_n_v[g]),
            .m_axis_tdata (td_s), .m_axis_tvalid (tvalid_w[g]),
            .m_axis_tready (tready_v[g]), .m_axis_tlast (tlast_w[g]),
            .overflow (ovf_w[g]), .frame_err (ferr_w[g]), .err_clear (err_clear_v[g])
        );
        assign tdata_w[g] = 32'(td_s);
    end

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge aclk);
        #2;
    endtask

    // Expected word: MSB-first keeps the transmitted value, LSB-first reverses its bits.
    function automatic logic [31:0] exp_word(input int g, input logic [31:0] v);
        logic [31:0] r;
        int w;
        w = DW_A[g];
        r = 32'h0;
        for (int i = 0; i < w; i++) begin
            r[i] = MSB_A[g] ? v[i] : v[w - 1 - i];
        end
        return r;
    endfunction

    task automatic clock_bit(input logic cpol, input logic cpha, input logic b);
        if (!cpha) begin
            spi_mosi = b;
            step(HALF);
            spi_clk = ~cpol;
            step(HALF);
            spi_clk = cpol;
        end else begin
            spi_clk = ~cpol;
            spi_mosi = b;
            step(HALF);
            spi_clk = cpol;
            step(HALF);
        end
    endtask

    // One CS frame of nw words from tx_words plus 'extra' trailing bits; the model
    // records the frame's beats (subject to FIFO capacity) and expected flags.
    task automatic send_frame(input int g, input int nw, input int extra);
        logic cpol, cpha;
        cpol = CPOL_A[g];
        cpha = CPHA_A[g];
        spi_clk = cpol;
        step(4);
        for (int i = 0; i < nw; i++) begin
            if (exp_q[g].size() < DEP_A[g]) begin
                exp_q[g].push_back({(i == nw - 1) ? 1'b1 : 1'b0, exp_word(g, tx_words[i])});
            end else begin
                exp_ovf[g] = 1'b1;
            end
        end
        if (extra > 0) exp_ferr[g] = 1'b1;
        cs_n_v[g] = 1'b0;
        step(HALF);
        for (int i = 0; i < nw; i++) begin
            for (int b = DW_A[g] - 1; b >= 0; b--) clock_bit(cpol, cpha, tx_words[i][b]);
        end
        for (int e = 0; e < extra; e++) clock_bit(cpol, cpha, e[0]);
        step(HALF);
        cs_n_v[g] = 1'b1;
        step(8);
    endtask

    task automatic drain(input int g);
        for (int i = 0; i < 300 && exp_q[g].size() != 0; i++) step(1);
        step(4);
        chk($sformatf("drain_%0d", g), 64'(exp_q[g].size()), 64'd0);
    endtask

    task automatic check_flags(input int g);
        chk($sformatf("overflow_%0d", g), 64'(ovf_w[g]), 64'(exp_ovf[g]));
        chk($sformatf("frame_err_%0d", g), 64'(ferr_w[g]), 64'(exp_ferr[g]));
    endtask

    task automatic clear_errs(input int g);
        err_clear_v[g] = 1'b1;
        step(1);
        err_clear_v[g] = 1'b0;
        exp_ovf[g] = 1'b0;
        exp_ferr[g] = 1'b0;
        step(2);
        check_flags(g);
    endtask

    // Compare process: every valid beat must match the model head; stalled beats must hold.
    always @(negedge aclk) begin
        if (aresetn) begin
            for (int g = 0; g < NI; g++) begin
                if (prev_hold[g]) begin
                    chk($sformatf("hold_valid_%0d", g), 64'(tvalid_w[g]), 64'd1);
                    chk($sformatf("hold_beat_%0d", g), 64'({tlast_w[g], tdata_w[g]}), 64'(prev_beat[g]));
                end
                if (tvalid_w[g]) begin
                    if (exp_q[g].size() == 0) begin
                        chk($sformatf("spurious_beat_%0d", g), 64'({tlast_w[g], tdata_w[g]}), 64'h1_dead_beef);
                    end else begin
                        chk($sformatf("beat_%0d", g), 64'({tlast_w[g], tdata_w[g]}), 64'(exp_q[g][0]));
                        if (tready_v[g]) begin
                            rx_log[g].push_back({tlast_w[g], tdata_w[g]});
                            void'(exp_q[g].pop_front());
                        end
                    end
                end
                prev_hold[g] = tvalid_w[g] && !tready_v[g];
                prev_beat[g] = {tlast_w[g], tdata_w[g]};
            end
        end else begin
            for (int g = 0; g < NI; g++) prev_hold[g] = 1'b0;
        end
    end

    initial begin
        aresetn = 1'b0;
        spi_clk = 1'b0;
        spi_mosi = 1'b0;
        cs_n_v = '1;
        tready_v = '1;
        err_clear_v = '0;
        for (int g = 0; g < NI; g++) begin
            exp_ovf[g] = 1'b0;
            exp_ferr[g] = 1'b0;
            prev_hold[g] = 1'b0;
        end
        step(4);
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("rst_tvalid_%0d", g), 64'(tvalid_w[g]), 64'd0);
            chk($sformatf("rst_tdata_%0d", g), 64'(tdata_w[g]), 64'd0);
            chk($sformatf("rst_tlast_%0d", g), 64'(tlast_w[g]), 64'd0);
            check_flags(g);
        end
        aresetn = 1'b1;
        step(4);

        // Mode 0 MSB-first two-byte frame.
        tx_words[0] = 32'hA5;
        tx_words[1] = 32'h3C;
        send_frame(0, 2, 0);
        drain(0);
        chk("t1_count", 64'(rx_log[0].size()), 64'd2);
        chk("t1_beat0", 64'(rx_log[0][0]), 64'h0_0000_00A5);
        chk("t1_beat1", 64'(rx_log[0][1]), 64'h1_0000_003C);
        check_flags(0);

        // All four modes plus LSB-first.
        for (int g = 0; g < 5; g++) begin
            rx_log[g].delete();
            tx_words[0] = 32'h81;
            send_frame(g, 1, 0);
            tx_words[0] = 32'h12;
            send_frame(g, 1, 0);
            drain(g);
            check_flags(g);
        end
        chk("t2_mode1_81", 64'(rx_log[1][0]), 64'h1_0000_0081);
        chk("t2_mode2_12", 64'(rx_log[2][1]), 64'h1_0000_0012);
        chk("t2_mode3_12", 64'(rx_log[3][1]), 64'h1_0000_0012);
        chk("t2_lsb_81", 64'(rx_log[4][0]), 64'h1_0000_0081);
        chk("t2_lsb_12", 64'(rx_log[4][1]), 64'h1_0000_0048);

        // 12-bit words.
        tx_words[0] = 32'hABC;
        tx_words[1] = 32'h123;
        tx_words[2] = 32'hFFF;
        send_frame(5, 3, 0);
        drain(5);
        chk("t3_count", 64'(rx_log[5].size()), 64'd3);
        chk("t3_w0", 64'(rx_log[5][0]), 64'h0_0000_0ABC);
        chk("t3_w1", 64'(rx_log[5][1]), 64'h0_0000_0123);
        chk("t3_w2", 64'(rx_log[5][2]), 64'h1_0000_0FFF);
        check_flags(5);

        // Overflow with a 4-deep FIFO and a stalled sink.
        tready_v[6] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tx_words[0] = 32'(i);
            send_frame(6, 1, 0);
        end
        step(4);
        chk("t4_overflow", 64'(ovf_w[6]), 64'd1);
        chk("t4_head", 64'({tlast_w[6], tdata_w[6]}), 64'h1_0000_0001);
        check_flags(6);
        tready_v[6] = 1'b1;
        drain(6);
        chk("t4_count", 64'(rx_log[6].size()), 64'd4);
        for (int i = 0; i < 4 && i < rx_log[6].size(); i++)
            chk($sformatf("t4_w%0d", i), 64'(rx_log[6][i]), 64'({1'b1, 32'(i + 1)}));
        clear_errs(6);

        // Partial trailing bits.
        rx_log[0].delete();
        tx_words[0] = 32'h55;
        send_frame(0, 1, 5);
        drain(0);
        chk("t5_count", 64'(rx_log[0].size()), 64'd1);
        chk("t5_beat", 64'(rx_log[0][0]), 64'h1_0000_0055);
        chk("t5_frame_err", 64'(ferr_w[0]), 64'd1);
        check_flags(0);
        clear_errs(0);

        // Reset in the middle of a word while two words are buffered.
        tready_v[0] = 1'b0;
        tx_words[0] = 32'h11;
        send_frame(0, 1, 0);
        tx_words[0] = 32'h22;
        send_frame(0, 1, 0);
        chk("t6_valid_before", 64'(tvalid_w[0]), 64'd1);
        cs_n_v[0] = 1'b0;
        step(HALF);
        for (int b = 0; b < 4; b++) clock_bit(1'b0, 1'b0, b[0]);
        aresetn = 1'b0;
        for (int g = 0; g < NI; g++) begin
            exp_q[g].delete();
            exp_ovf[g] = 1'b0;
            exp_ferr[g] = 1'b0;
        end
        step(1);
        chk("t6_valid_after_rst", 64'(tvalid_w[0]), 64'd0);
        aresetn = 1'b1;
        tready_v[0] = 1'b1;
        for (int b = 0; b < 4; b++) clock_bit(1'b0, 1'b0, 1'b1);
        step(HALF);
        cs_n_v[0] = 1'b1;
        step(8);
        rx_log[0].delete();
        tx_words[0] = 32'h7E;
        send_frame(0, 1, 0);
        drain(0);
        chk("t6_count", 64'(rx_log[0].size()), 64'd1);
        chk("t6_beat", 64'(rx_log[0][0]), 64'h1_0000_007E);
        for (int g = 0; g < NI; g++) check_flags(g);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
